// File: rtl/instr_encoder.sv
// Instruction encoder/loader: packs symbolic fields into 9-bit words, buffers them in a FIFO
// and writes them to instruction memory. Optional Csum output under INSTR_ENCODER_CSUM_EN.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [1:0]    i_in_type,
  input  logic [2:0]    i_in_op,
  input  logic [6:0]    i_in_operand,
  input  logic          i_in_last,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [8:0]    o_wr_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err,
  output logic [AW:0]   o_count
`ifdef INSTR_ENCODER_CSUM_EN
  ,
  output logic [8:0]    o_csum
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [8:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_fill;
  logic [AW-1:0] r_wr_addr;
  logic [AW:0]   r_acc_addr;
  logic [AW:0]   r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_in_ready;
  logic          w_accept;
  logic          w_legal;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_session;
  logic          w_wr_en;
  logic [8:0]    w_word;

  function automatic logic [8:0] encode(input logic [1:0] t, input logic [2:0] op,
                                        input logic [6:0] opd);
    case (t)
      2'd0:       encode = {t, opd};
      2'd1, 2'd3: encode = {t, op[1:0], opd[4:0]};
      2'd2:       encode = {t, op, opd[3:0]};
      default:    encode = 9'd0;
    endcase
  endfunction

  function automatic logic fields_ok(input logic [1:0] t, input logic [2:0] op,
                                     input logic [6:0] opd);
    case (t)
      2'd1, 2'd3: fields_ok = !op[2] && (opd <= 7'd31);
      2'd2:       fields_ok = (opd <= 7'd15);
      default:    fields_ok = 1'b1;
    endcase
  endfunction

  // Handshake, legality, FIFO control and next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    w_empty     = (r_fill == {(PW+1){1'b0}});
    w_full      = (r_fill == (PW+1)'(DEPTH));
    w_in_ready  = (r_state == S_LOAD) && !w_full;
    w_accept    = i_in_valid && w_in_ready;
    // The address check covers the word being accepted, so it uses the next-accept address.
    w_legal     = fields_ok(i_in_type, i_in_op, i_in_operand) && !r_acc_addr[AW];
    w_word      = encode(i_in_type, i_in_op, i_in_operand);
    w_wr_en     = ((r_state == S_LOAD) || (r_state == S_DRAIN)) && !w_empty;
    w_session   = i_start && ((r_state == S_IDLE) || (r_state == S_ERROR));
    w_push      = w_accept && w_legal;
    w_pop       = w_wr_en;
    w_flush     = (w_accept && !w_legal) || w_session;
    case (r_state)
      S_IDLE: begin
        if (w_session) w_state_nxt = S_LOAD;
        else           w_state_nxt = S_IDLE;
      end
      S_LOAD: begin
        if (w_accept && !w_legal)        w_state_nxt = S_ERROR;
        else if (w_accept && i_in_last)  w_state_nxt = S_DRAIN;
        else                             w_state_nxt = S_LOAD;
      end
      S_DRAIN: begin
        if (w_empty) w_state_nxt = S_IDLE;
        else         w_state_nxt = S_DRAIN;
      end
      S_ERROR: begin
        if (w_session) w_state_nxt = S_LOAD;
        else           w_state_nxt = S_ERROR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || w_flush) begin
      r_rd_ptr <= {PW{1'b0}};
      r_wr_ptr <= {PW{1'b0}};
      r_fill   <= {(PW+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_fill <= r_fill + (PW+1)'(1);
        2'b01:   r_fill <= r_fill - (PW+1)'(1);
        default: r_fill <= r_fill;
      endcase
    end
  end

  // FIFO storage; contents are only observed through the occupancy-gated head.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Write address, next-accept address and written-word count.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_wr_addr  <= {AW{1'b0}};
      r_acc_addr <= {(AW+1){1'b0}};
      r_count    <= {(AW+1){1'b0}};
    end else if (w_session) begin
      r_wr_addr  <= i_base_addr;
      r_acc_addr <= {1'b0, i_base_addr};
      r_count    <= {(AW+1){1'b0}};
    end else begin
      if (w_pop) begin
        r_wr_addr <= r_wr_addr + AW'(1);
        r_count   <= r_count + (AW+1)'(1);
      end
      if (w_push) r_acc_addr <= r_acc_addr + (AW+1)'(1);
    end
  end

`ifdef INSTR_ENCODER_CSUM_EN
  logic [8:0] r_csum;

  // Running XOR of every word written this session.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || w_session) r_csum <= 9'd0;
    else if (w_pop)              r_csum <= r_csum ^ r_mem[r_rd_ptr];
    else                         r_csum <= r_csum;
  end

  assign o_csum = r_csum;
`endif

  assign o_in_ready = w_in_ready;
  assign o_wr_en    = w_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = w_wr_en ? r_mem[r_rd_ptr] : 9'd0;
  assign o_busy     = (r_state == S_LOAD) || (r_state == S_DRAIN);
  assign o_done     = (r_state == S_DRAIN) && w_empty;
  assign o_err      = (r_state == S_ERROR);
  assign o_count    = r_count;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: spec-level model checked every cycle plus directed literals.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          i_reset_n, i_start, i_in_valid, i_in_last;
  logic [AW-1:0] i_base_addr;
  logic [1:0]    i_in_type;
  logic [2:0]    i_in_op;
  logic [6:0]    i_in_operand;
  logic          o_in_ready, o_wr_en, o_busy, o_done, o_err;
  logic [AW-1:0] o_wr_addr;
  logic [8:0]    o_wr_data;
  logic [AW:0]   o_count;
`ifdef INSTR_ENCODER_CSUM_EN
  logic [8:0]    o_csum;
`endif

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_type(i_in_type),
    .i_in_op(i_in_op), .i_in_operand(i_in_operand), .i_in_last(i_in_last),
    .o_wr_en(o_wr_en), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_count(o_count)
`ifdef INSTR_ENCODER_CSUM_EN
    , .o_csum(o_csum)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level model: session mode, queue of words waiting to be written, counters.
  typedef enum {M_IDLE, M_LOAD, M_DRAIN, M_ERROR} mode_t;
  mode_t mode = M_IDLE;
  bit    m_valid = 1'b0;
  int    m_acc = 0, m_written = 0, m_csum = 0;
  int    q_addr[$], q_data[$];
  int    wlog_addr[$], wlog_data[$];
  int    done_cnt = 0;

  function automatic bit f_legal(input int t, input int op, input int opd, input int addr);
    if (addr > 255) return 1'b0;
    if (t == 1 || t == 3) return (op < 4) && (opd < 32);
    if (t == 2) return opd < 16;
    return 1'b1;
  endfunction

  function automatic int f_enc(input int t, input int op, input int opd);
    if (t == 0) return opd;
    if (t == 2) return 256 + op * 16 + opd % 16;
    return t * 128 + (op % 4) * 32 + opd % 32;
  endfunction

  // Compare process: sample at negedge, then advance the model to the next edge.
  initial begin
    mode_t cur;
    bit exp_ready, exp_wr, exp_done;
    forever begin
      @(negedge clk);
      cur = mode;
      exp_ready = (cur == M_LOAD) && (q_data.size() < DEPTH);
      exp_wr    = (cur == M_LOAD || cur == M_DRAIN) && (q_data.size() > 0);
      exp_done  = (cur == M_DRAIN) && (q_data.size() == 0);
      if (m_valid) begin
        check("in_ready", 32'(o_in_ready), 32'(exp_ready));
        check("wr_en", 32'(o_wr_en), 32'(exp_wr));
        check("done", 32'(o_done), 32'(exp_done));
        check("busy", 32'(o_busy), 32'(cur == M_LOAD || cur == M_DRAIN));
        check("err", 32'(o_err), 32'(cur == M_ERROR));
        check("count", 32'(o_count), 32'(m_written));
        if (o_wr_en === 1'b1) begin
          wlog_addr.push_back(int'(o_wr_addr));
          wlog_data.push_back(int'(o_wr_data));
        end
        if (o_done === 1'b1) done_cnt++;
        if (exp_wr) begin
          check("wr_addr", 32'(o_wr_addr), 32'(q_addr[0]));
          check("wr_data", 32'(o_wr_data), 32'(q_data[0]));
          m_csum = m_csum ^ q_data[0];
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          m_written++;
        end
`ifdef INSTR_ENCODER_CSUM_EN
        if (exp_done) check("csum_at_done", 32'(o_csum), 32'(m_csum));
`endif
        if (exp_done) mode = M_IDLE;
      end
      if (!i_reset_n) begin
        mode = M_IDLE; q_addr.delete(); q_data.delete();
        m_written = 0; m_acc = 0; m_csum = 0; m_valid = 1'b1;
      end else if (m_valid) begin
        if (i_start && (cur == M_IDLE || cur == M_ERROR)) begin
          mode = M_LOAD; m_acc = int'(i_base_addr); m_written = 0; m_csum = 0;
          q_addr.delete(); q_data.delete();
        end else if (cur == M_LOAD && i_in_valid && exp_ready) begin
          if (f_legal(int'(i_in_type), int'(i_in_op), int'(i_in_operand), m_acc)) begin
            q_addr.push_back(m_acc % 256);
            q_data.push_back(f_enc(int'(i_in_type), int'(i_in_op), int'(i_in_operand)));
            m_acc++;
            if (i_in_last) mode = M_DRAIN;
          end else begin
            mode = M_ERROR; q_addr.delete(); q_data.delete();
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] base);
    i_start = 1'b1; i_base_addr = base;
    cyc(1);
    i_start = 1'b0;
  endtask

  task automatic send(input int t, input int op, input int opd, input bit last);
    i_in_valid = 1'b1; i_in_type = 2'(t); i_in_op = 3'(op);
    i_in_operand = 7'(opd); i_in_last = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (o_in_ready === 1'b1) begin
        cyc(1);
        i_in_valid = 1'b0; i_in_last = 1'b0;
        return;
      end
    end
    check("send_accept_timeout", 32'(o_in_ready), 32'd1);
    i_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) begin
      if (o_busy === 1'b0) begin
        cyc(2);
        return;
      end
      cyc(1);
    end
    check("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  initial begin
    int b, d;
    i_reset_n = 1'b0; i_start = 1'b0; i_base_addr = 8'h00; i_in_valid = 1'b0;
    i_in_type = 2'd0; i_in_op = 3'd0; i_in_operand = 7'd0; i_in_last = 1'b0;
    cyc(3);
    check("rst_in_ready", 32'(o_in_ready), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_wr_en", 32'(o_wr_en), 32'd0);
    i_reset_n = 1'b1;
    cyc(1);

    // Single R ADD 5 with InLast at 0x10.
    b = wlog_addr.size(); d = done_cnt;
    do_start(8'h10);
    send(2, 0, 5, 1'b1);
    check("t1_wr_en_next", 32'(o_wr_en), 32'd1);
    cyc(1);
    check("t1_done_pulse", 32'(o_done), 32'd1);
    check("t1_count", 32'(o_count), 32'd1);
    cyc(1);
    check("t1_done_one_cycle", 32'(o_done), 32'd0);
    check("t1_addr", 32'(wlog_addr[b]), 32'h10);
    check("t1_data", 32'(wlog_data[b]), 32'h105);
    check("t1_nwr", 32'(wlog_addr.size() - b), 32'd1);
    check("t1_ndone", 32'(done_cnt - d), 32'd1);
    wait_idle();

    // Back-to-back M STR 3, B BLT 31, I 0x55.
    b = wlog_addr.size(); d = done_cnt;
    do_start(8'h00);
    send(1, 1, 3, 1'b0);
    send(3, 2, 31, 1'b0);
    send(0, 0, 8'h55, 1'b1);
    wait_idle();
    check("t2_nwr", 32'(wlog_addr.size() - b), 32'd3);
    check("t2_d0", 32'(wlog_data[b]), 32'h0A3);
    check("t2_d1", 32'(wlog_data[b+1]), 32'h1DF);
    check("t2_d2", 32'(wlog_data[b+2]), 32'h055);
    check("t2_a2", 32'(wlog_addr[b+2]), 32'd2);
    check("t2_count", 32'(o_count), 32'd3);
    check("t2_ndone", 32'(done_cnt - d), 32'd1);

`ifdef INSTR_ENCODER_CSUM_EN
    do_start(8'h00);
    send(2, 0, 5, 1'b0);
    send(1, 1, 3, 1'b1);
    for (int k = 0; k < 20 && o_done !== 1'b1; k++) cyc(1);
    check("csum_lit", 32'(o_csum), 32'h1A6);
    wait_idle();
`endif

    // Continuous stream of 10 words; Start mid-session must be ignored.
    b = wlog_addr.size(); d = done_cnt;
    do_start(8'h40);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin i_start = 1'b1; i_base_addr = 8'h77; end
      send(0, 0, i + 7, i == 9);
      if (i == 4) i_start = 1'b0;
    end
    wait_idle();
    check("t3_nwr", 32'(wlog_addr.size() - b), 32'd10);
    for (int i = 0; i < 10; i++) begin
      check("t3_addr", 32'(wlog_addr[b+i]), 32'(8'h40 + i));
      check("t3_data", 32'(wlog_data[b+i]), 32'(i + 7));
    end
    check("t3_ndone", 32'(done_cnt - d), 32'd1);

    // InValid in IDLE is ignored.
    b = wlog_addr.size();
    i_in_valid = 1'b1; i_in_type = 2'd0; i_in_operand = 7'h22;
    cyc(3);
    i_in_valid = 1'b0;
    check("idle_valid_ignored", 32'(wlog_addr.size() - b), 32'd0);

    // R operand 16 mid-session, then recover with Start at 0x20.
    b = wlog_addr.size();
    do_start(8'h00);
    send(2, 0, 1, 1'b0);
    send(2, 0, 16, 1'b0);
    cyc(2);
    check("t4_err", 32'(o_err), 32'd1);
    i_in_valid = 1'b1; i_in_type = 2'd0; i_in_operand = 7'h01;
    cyc(3);
    i_in_valid = 1'b0;
    check("t4_nwr", 32'(wlog_addr.size() - b), 32'd1);
    do_start(8'h20);
    check("t4_err_cleared", 32'(o_err), 32'd0);
    send(0, 0, 8'h11, 1'b1);
    wait_idle();
    check("t4_rec_addr", 32'(wlog_addr[wlog_addr.size()-1]), 32'h20);
    check("t4_rec_data", 32'(wlog_data[wlog_data.size()-1]), 32'h011);

    // Address overflow from base 0xFF.
    b = wlog_addr.size(); d = done_cnt;
    do_start(8'hFF);
    send(0, 0, 1, 1'b0);
    send(0, 0, 2, 1'b1);
    cyc(3);
    check("t5_err", 32'(o_err), 32'd1);
    check("t5_nwr", 32'(wlog_addr.size() - b), 32'd1);
    check("t5_addr", 32'(wlog_addr[b]), 32'hFF);
    check("t5_count", 32'(o_count), 32'd1);
    check("t5_no_done", 32'(done_cnt - d), 32'd0);

    // Reset during DRAIN with a word still buffered.
    d = done_cnt;
    do_start(8'h00);
    send(0, 0, 3, 1'b0);
    send(0, 0, 4, 1'b0);
    send(0, 0, 5, 1'b1);
    i_reset_n = 1'b0;
    cyc(1);
    check("t6_wr_en", 32'(o_wr_en), 32'd0);
    check("t6_busy", 32'(o_busy), 32'd0);
    check("t6_count", 32'(o_count), 32'd0);
    check("t6_ready", 32'(o_in_ready), 32'd0);
    i_reset_n = 1'b1;
    cyc(4);
    check("t6_no_done", 32'(done_cnt - d), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
